// File: rtl/c1_logic_cell_pkg.sv
`default_nettype none
// ============================================================================
// Module   : c1_pkg
// Purpose  : Shared constants and the C1 input-bundle type for netlist builders.
//            C1_ZERO / C1_ONE are the tie-off levels used when a C1 cell is
//            mapped to a gate (AND, XOR, AND-NOT, ...).
// Contents : C1_ZERO, C1_ONE  - tie levels
//            c1_in_t          - packed {a0,a1,sa,b0,b1,sb,s0,s1}, a0 is MSB
// Revision : 1.0 - initial release
// ============================================================================
package c1_pkg;

    localparam logic C1_ZERO = 1'b0;
    localparam logic C1_ONE  = 1'b1;

    // Fixed mux data-port order of one C1 slice.
    typedef struct packed {
        logic a0;
        logic a1;
        logic sa;
        logic b0;
        logic b1;
        logic sb;
        logic s0;
        logic s1;
    } c1_in_t;

endpackage
`default_nettype wire

// File: rtl/c1_logic_cell_if.sv
`default_nettype none
// ============================================================================
// Module   : c1_logic_cell_if
// Purpose  : Bundles the per-slice data, select and enable inputs and the
//            f/q outputs of the C1 logic cell. All data signals are WIDTH
//            bits, bit i belongs to slice i.
// Modports : master - drives a0,a1,sa,b0,b1,sb,s0,s1,en; observes f,q(,sel_b)
//            slave  - the cell side
// Options  : C1_SEL_OBS_EN adds sel_b (per-slice s0|s1 observation)
// Revision : 1.0 - initial release
// ============================================================================
interface c1_logic_cell_if #(
    parameter int WIDTH = 1
);
    logic [WIDTH-1:0] a0;
    logic [WIDTH-1:0] a1;
    logic [WIDTH-1:0] sa;
    logic [WIDTH-1:0] b0;
    logic [WIDTH-1:0] b1;
    logic [WIDTH-1:0] sb;
    logic [WIDTH-1:0] s0;
    logic [WIDTH-1:0] s1;
    logic             en;
    logic [WIDTH-1:0] f;
    logic [WIDTH-1:0] q;
`ifdef C1_SEL_OBS_EN
    logic [WIDTH-1:0] sel_b;
`endif

    modport master (
        output a0, a1, sa, b0, b1, sb, s0, s1, en,
`ifdef C1_SEL_OBS_EN
        input  sel_b,
`endif
        input  f, q
    );

    modport slave (
        input  a0, a1, sa, b0, b1, sb, s0, s1, en,
`ifdef C1_SEL_OBS_EN
        output sel_b,
`endif
        output f, q
    );

endinterface
`default_nettype wire

// File: rtl/c1_logic_cell_mux2.sv
`default_nettype none
// ============================================================================
// Module   : c1_mux2
// Purpose  : Single-bit 2:1 mux, the building block of a C1 slice.
// Ports    : d0_i - data when s_i = 0
//            d1_i - data when s_i = 1
//            s_i  - select
//            y_o  - mux output
// Revision : 1.0 - initial release
// ============================================================================
module c1_mux2 (
    input  wire logic d0_i,
    input  wire logic d1_i,
    input  wire logic s_i,
    output logic      y_o
);

    // Plain ternary: an X select merges d0/d1 (equal data stays known)
    // instead of being forced to a fixed value.
    assign y_o = s_i ? d1_i : d0_i;

endmodule
`default_nettype wire

// File: rtl/c1_logic_cell.sv
`default_nettype none
// ============================================================================
// Module   : c1_logic_cell
// Purpose  : WIDTH independent ACT1-style C1 logic slices. Per slice:
//              ma = sa ? a1 : a0;  mb = sb ? b1 : b0;  f = (s0|s1) ? mb : ma
//            f is combinational; q is f registered under en, cleared
//            asynchronously by rst.
// Ports    : clk - rising-edge clock for q
//            rst - asynchronous active-high reset, clears q
//            bus - c1_logic_cell_if.slave (a0..s1, en in; f, q out)
// Options  : C1_SEL_OBS_EN drives bus.sel_b = s0|s1 per slice
// Revision : 1.0 - initial release
// ============================================================================
module c1_logic_cell
    import c1_pkg::*;
#(
    parameter int WIDTH = 1
) (
    input  wire logic        clk,
    input  wire logic        rst,
    c1_logic_cell_if.slave   bus
);

    logic [WIDTH-1:0] ma_w;
    logic [WIDTH-1:0] mb_w;
    logic [WIDTH-1:0] sel_w;
    logic [WIDTH-1:0] f_w;
    logic [WIDTH-1:0] q_d;
    logic [WIDTH-1:0] q_q;

    // The output mux select is the OR of s0/s1; an X on either still feeds
    // the mux select rather than gating the data.
    assign sel_w = bus.s0 | bus.s1;

    for (genvar i = 0; i < WIDTH; i++) begin : g_slice
        c1_mux2 u_mux_a (
            .d0_i (bus.a0[i]),
            .d1_i (bus.a1[i]),
            .s_i  (bus.sa[i]),
            .y_o  (ma_w[i])
        );

        c1_mux2 u_mux_b (
            .d0_i (bus.b0[i]),
            .d1_i (bus.b1[i]),
            .s_i  (bus.sb[i]),
            .y_o  (mb_w[i])
        );

        c1_mux2 u_mux_f (
            .d0_i (ma_w[i]),
            .d1_i (mb_w[i]),
            .s_i  (sel_w[i]),
            .y_o  (f_w[i])
        );
    end

    always_comb begin
        q_d = q_q;
        if (bus.en) begin
            q_d = f_w;
        end
    end

    // A clock edge seen while rst is still high takes the reset branch, so
    // the first load after release happens on the following edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            q_q <= {WIDTH{C1_ZERO}};
        end else begin
            q_q <= q_d;
        end
    end

    assign bus.f = f_w;
    assign bus.q = q_q;

`ifdef C1_SEL_OBS_EN
    assign bus.sel_b = sel_w;
`endif

endmodule
`default_nettype wire

// File: tb/tb_c1_logic_cell.sv
`default_nettype none
// ============================================================================
// Module   : tb_c1_logic_cell
// Purpose  : Directed self-checking bench for c1_logic_cell with WIDTH=4.
//            Exhaustive single-slice sweep (all slices driven alike), a 2-bit
//            multiplier mapped onto the four slices, register/reset checks and
//            per-slice distinct vectors.
// Options  : C1_SEL_OBS_EN additionally checks sel_b
// Revision : 1.0 - initial release
// ============================================================================
module tb_c1_logic_cell;
    import c1_pkg::*;

    localparam int W = 4;

    logic clk = 1'b0;
    logic rst = 1'b0;

    int n_vec = 0;
    int n_err = 0;

    c1_logic_cell_if #(.WIDTH(W)) bus ();

    c1_logic_cell #(.WIDTH(W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [W-1:0] obs,
                         input logic [W-1:0] exp);
        n_vec++;
        assert (obs === exp)
        else begin
            n_err++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic drive_all(input c1_in_t v);
        bus.a0 = {W{v.a0}};
        bus.a1 = {W{v.a1}};
        bus.sa = {W{v.sa}};
        bus.b0 = {W{v.b0}};
        bus.b1 = {W{v.b1}};
        bus.sb = {W{v.sb}};
        bus.s0 = {W{v.s0}};
        bus.s1 = {W{v.s1}};
    endtask

    // Reference in sum-of-products form.
    function automatic logic ref_f(input c1_in_t v);
        logic sel;
        sel = v.s0 | v.s1;
        return (~sel & ((~v.sa & v.a0) | (v.sa & v.a1))) |
               ( sel & ((~v.sb & v.b0) | (v.sb & v.b1)));
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        c1_in_t v;
        logic   p00, p01, p10, p11;
        logic [3:0] prod;

        bus.en = 1'b0;
        drive_all(8'h00);

        // Async reset without any clock edge (first posedge at t=5).
        #1 rst = 1'b1;
        #1 check("reset_q_no_clk", bus.q, 4'b0000);

        // Exhaustive sweep, all slices identical.
        for (int i = 0; i < 256; i++) begin
            v = c1_in_t'(i[7:0]);
            drive_all(v);
            #1;
            check($sformatf("sweep_%0d", i), bus.f, {W{ref_f(v)}});
        end

        // Gate mappings from the cell description.
        for (int i = 0; i < 4; i++) begin
            logic x, y;
            x = i[1];
            y = i[0];
            drive_all({C1_ZERO, x, y, C1_ZERO, C1_ZERO, C1_ZERO, C1_ZERO, C1_ZERO});
            #1 check($sformatf("and_%0d", i), bus.f, {W{x & y}});
            drive_all({C1_ZERO, C1_ONE, y, C1_ONE, C1_ZERO, y, x, C1_ZERO});
            #1 check($sformatf("xor_%0d", i), bus.f, {W{x ^ y}});
        end

        // 2-bit multiplier: slice k produces product bit k.
        for (int a = 0; a < 4; a++) begin
            for (int b = 0; b < 4; b++) begin
                p00 = a[0] & b[0];
                p01 = a[0] & b[1];
                p10 = a[1] & b[0];
                p11 = a[1] & b[1];
                //          bit3        bit2     bit1    bit0
                bus.a0 = {1'b0,      p11,     1'b0,   1'b0};
                bus.a1 = {p00,       1'b0,    1'b1,   a[0] ? 1'b1 : 1'b0};
                bus.sa = {p11,       p00,     p01,    b[0] ? 1'b1 : 1'b0};
                bus.b0 = {1'b0,      1'b0,    1'b1,   1'b0};
                bus.b1 = {1'b0,      1'b0,    1'b0,   1'b0};
                bus.sb = {1'b0,      1'b0,    p01,    1'b0};
                bus.s0 = {1'b0,      1'b0,    p10,    1'b0};
                bus.s1 = 4'b0000;
                #1;
                prod = 4'(a * b);
                check($sformatf("mult_%0dx%0d", a, b), bus.f, prod);
            end
        end

        // Register: q stays 0 while rst held, even with en=1 and clocking.
        drive_all({C1_ZERO, C1_ONE, C1_ONE, C1_ZERO, C1_ZERO, C1_ZERO, C1_ZERO, C1_ZERO});
        bus.en = 1'b1;
        tick();
        check("q_held_in_reset", bus.q, 4'b0000);
        rst = 1'b0;
        #1 check("q_after_release", bus.q, 4'b0000);
        tick();
        check("q_load_f1", bus.q, 4'b1111);

        // en=0: q holds while f toggles.
        bus.en = 1'b0;
        bus.a1 = 4'b0000;
        #1 check("f_toggle_low", bus.f, 4'b0000);
        tick();
        check("q_hold_1", bus.q, 4'b1111);
        bus.a1 = 4'b1111;
        tick();
        bus.a1 = 4'b0101;
        tick();
        check("q_hold_2", bus.q, 4'b1111);

        // en=1 loads the new pattern.
        bus.en = 1'b1;
        tick();
        check("q_load_pattern", bus.q, 4'b0101);
        bus.a1 = 4'b1111;
        tick();
        check("q_reload", bus.q, 4'b1111);

        // Async reset mid-run, between edges; f keeps tracking inputs.
        #2 rst = 1'b1;
        #1 check("q_async_clear", bus.q, 4'b0000);
        check("f_during_reset", bus.f, 4'b1111);
        bus.a1 = 4'b0011;
        #1 check("f_track_in_reset", bus.f, 4'b0011);
        rst = 1'b0;
        tick();
        check("q_after_midrun", bus.q, 4'b0011);

        // Per-slice distinct vectors.
        bus.a0 = 4'b0011;
        bus.a1 = 4'b0101;
        bus.sa = 4'b1100;
        bus.b0 = 4'b1001;
        bus.b1 = 4'b0110;
        bus.sb = 4'b0101;
        bus.s0 = 4'b1010;
        bus.s1 = 4'b0000;
        #1 check("slices_s0", bus.f, 4'b1101);
`ifdef C1_SEL_OBS_EN
        check("sel_b_s0", bus.sel_b, 4'b1010);
`endif
        bus.s0 = 4'b0000;
        bus.s1 = 4'b0101;
        #1 check("slices_s1", bus.f, 4'b0110);
`ifdef C1_SEL_OBS_EN
        check("sel_b_s1", bus.sel_b, 4'b0101);
`endif
        tick();
        check("q_slices", bus.q, 4'b0110);

        // X select with equal data must not collapse to 0.
        drive_all(8'h00);
        bus.a0 = 4'b1111;
        bus.a1 = 4'b1111;
        bus.sa = 4'bxxxx;
        #1 check("x_sel_equal_data", bus.f, 4'b1111);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
